// File: rtl/reset_sequencer_if.sv
// Soft-reset handshake and per-domain reset outputs of reset_sequencer.
// The requester (CPU side) uses master; the sequencer uses slave.
interface reset_sequencer_if #(
    parameter int NSTAGES = 3
);
    logic               soft_req;
    logic               soft_ack;
    logic [NSTAGES-1:0] stage_rstn;
    logic               all_ready;
    logic [1:0]         cause;

    modport master (output soft_req, input soft_ack, stage_rstn, all_ready, cause);
    modport slave  (input soft_req, output soft_ack, stage_rstn, all_ready, cause);
endinterface

// File: rtl/reset_sequencer.sv
// Synchronizes board reset release, then releases NSTAGES domain resets with a
// hold and a stagger; also services a 4-phase soft-reset request from the CPU.
module reset_sequencer #(
    parameter int HOLD_CYCLES = 16,
    parameter int STAGGER     = 4,
    parameter int NSTAGES     = 3,
    parameter int SOFT_MIN    = 8
) (
    input  logic             clk,
    input  logic             resetn,
    reset_sequencer_if.slave seq_if
);
    localparam int MAX_HS  = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
    localparam int MAX_CNT = (MAX_HS > SOFT_MIN) ? MAX_HS : SOFT_MIN;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int IDX_W   = (NSTAGES > 1) ? $clog2(NSTAGES) : 1;

    // The edge that first sees the synchronized reset already counts as hold
    // cycle 1, so the hold counter starts two below HOLD_CYCLES.
    localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'((HOLD_CYCLES > 1) ? HOLD_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0] STAGGER_LOAD = CNT_W'(STAGGER - 1);
    localparam logic [CNT_W-1:0] SOFT_LOAD    = CNT_W'(SOFT_MIN - 1);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NSTAGES - 1);

    typedef enum logic [2:0] {SYNC, HOLD, RELEASE, RUN, SOFT, ACK} state_e;
    typedef enum logic [1:0] {CAUSE_POR = 2'b01, CAUSE_SOFT = 2'b10} cause_e;

    logic [1:0]         sync_q;
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NSTAGES-1:0] stage_q, stage_d;
    logic               all_ready_q, all_ready_d;
    logic               soft_ack_q, soft_ack_d;
    cause_e             cause_q, cause_d;

    logic               rel_en;
    logic [IDX_W-1:0]   rel_idx;
    logic               soft_start;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop regardless of block order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q      <= '0;
            state_q     <= SYNC;
            cnt_q       <= '0;
            idx_q       <= '0;
            stage_q     <= '0;
            all_ready_q <= 1'b0;
            soft_ack_q  <= 1'b0;
            cause_q     <= CAUSE_POR;
        end else begin
            sync_q      <= {sync_q[0], 1'b1};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            stage_q     <= stage_d;
            all_ready_q <= all_ready_d;
            soft_ack_q  <= soft_ack_d;
            cause_q     <= cause_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        rel_en     = 1'b0;
        rel_idx    = idx_q;
        soft_start = 1'b0;

        unique case (state_q)
            SYNC: begin
                if (sync_q[1]) begin
                    if (HOLD_CYCLES == 1) begin
                        rel_en  = 1'b1;
                        rel_idx = '0;
                    end else begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LOAD;
                    end
                end
            end
            HOLD, SOFT: begin
                if (cnt_q == '0) begin
                    rel_en  = 1'b1;
                    rel_idx = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RELEASE: begin
                if (cnt_q == '0) rel_en = 1'b1;
                else             cnt_d  = cnt_q - CNT_W'(1);
            end
            RUN: begin
                if (seq_if.soft_req) begin
                    soft_start = 1'b1;
                    state_d    = SOFT;
                    cnt_d      = SOFT_LOAD;
                end
            end
            ACK: begin
                if (soft_ack_q && !seq_if.soft_req) state_d = RUN;
            end
            default: state_d = SYNC;
        endcase

        // Soft sequences end in ACK; power-on sequences go straight to RUN.
        if (rel_en) begin
            if (rel_idx == LAST_IDX) begin
                state_d = (cause_q == CAUSE_SOFT) ? ACK : RUN;
                cnt_d   = '0;
            end else begin
                state_d = RELEASE;
                idx_d   = rel_idx + IDX_W'(1);
                cnt_d   = STAGGER_LOAD;
            end
        end
    end

    always_comb begin
        stage_d = stage_q;
        if (soft_start) stage_d = '0;
        if (rel_en)     stage_d[rel_idx] = 1'b1;

        all_ready_d = (&stage_q) & (&stage_d);
        cause_d     = soft_start ? CAUSE_SOFT : cause_q;
        // Ack rises unconditionally on the first ACK edge, then follows soft_req.
        soft_ack_d  = (state_q == ACK) && (!soft_ack_q || seq_if.soft_req);
    end

    assign seq_if.stage_rstn = stage_q;
    assign seq_if.all_ready  = all_ready_q;
    assign seq_if.soft_ack   = soft_ack_q;
    assign seq_if.cause      = cause_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Directed checks of reset_sequencer: default build plus a minimum-parameter build.
module tb_reset_sequencer;
    logic clk    = 1'b0;
    logic resetn = 1'b1;
    int   tests  = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    reset_sequencer_if #(.NSTAGES(3)) d_if ();
    reset_sequencer_if #(.NSTAGES(1)) s_if ();

    reset_sequencer dut (
        .clk    (clk),
        .resetn (resetn),
        .seq_if (d_if.slave)
    );

    reset_sequencer #(
        .HOLD_CYCLES (1),
        .STAGGER     (1),
        .NSTAGES     (1),
        .SOFT_MIN    (1)
    ) dut_min (
        .clk    (clk),
        .resetn (resetn),
        .seq_if (s_if.slave)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_d(input string tag, input logic [2:0] stage, input logic ar,
                           input logic ack, input logic [1:0] cause);
        check({tag, " d.stage"}, 8'(d_if.stage_rstn), 8'(stage));
        check({tag, " d.ready"}, 8'(d_if.all_ready),  8'(ar));
        check({tag, " d.ack"},   8'(d_if.soft_ack),   8'(ack));
        check({tag, " d.cause"}, 8'(d_if.cause),      8'(cause));
    endtask

    task automatic check_s(input string tag, input logic stage, input logic ar,
                           input logic ack, input logic [1:0] cause);
        check({tag, " s.stage"}, 8'(s_if.stage_rstn), 8'(stage));
        check({tag, " s.ready"}, 8'(s_if.all_ready),  8'(ar));
        check({tag, " s.ack"},   8'(s_if.soft_ack),   8'(ack));
        check({tag, " s.cause"}, 8'(s_if.cause),      8'(cause));
    endtask

    // Returns 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Releases resetn before edge 0 and checks both builds edge by edge.
    task automatic por_check(input int last_e, input bit soft_high);
        logic [2:0] es;
        resetn = 1'b1;
        for (int e = 0; e <= 25 && e <= last_e; e++) begin
            step();
            es = {e >= 25, e >= 21, e >= 17};
            check_d($sformatf("por e%0d", e), es, 1'b0, 1'b0, 2'b01);
            check_s($sformatf("por e%0d", e), e >= 2, e >= 3, 1'b0, 2'b01);
        end
        if (last_e > 25) begin
            for (int e = 26; e <= 27; e++) begin
                step();
                if (soft_high) check_d($sformatf("por e%0d", e), 3'b000, 1'b0, 1'b0, 2'b10);
                else           check_d($sformatf("por e%0d", e), 3'b111, 1'b1, 1'b0, 2'b01);
                check_s($sformatf("por e%0d", e), 1'b1, 1'b1, 1'b0, 2'b01);
            end
        end
    endtask

    // Drops resetn between clock edges and checks outputs clear without an edge.
    task automatic async_reset(input string tag);
        #2 resetn = 1'b0;
        #1;
        check_d({tag, " async"}, 3'b000, 1'b0, 1'b0, 2'b01);
        check_s({tag, " async"}, 1'b0, 1'b0, 1'b0, 2'b01);
        repeat (3) step();
    endtask

    initial begin
        d_if.soft_req = 1'b0;
        s_if.soft_req = 1'b0;

        // Power-on with defaults and with minimum parameters.
        #2 resetn = 1'b0;
        #1;
        check_d("reset", 3'b000, 1'b0, 1'b0, 2'b01);
        check_s("reset", 1'b0, 1'b0, 1'b0, 2'b01);
        repeat (5) step();
        por_check(27, 1'b0);

        // Minimum-parameter soft reset: release at N+1, ack at N+2.
        s_if.soft_req = 1'b1;
        step(); check_s("min soft N",   1'b0, 1'b0, 1'b0, 2'b10);
        step(); check_s("min soft N+1", 1'b1, 1'b0, 1'b0, 2'b10);
        step(); check_s("min soft N+2", 1'b1, 1'b1, 1'b1, 2'b10);
        s_if.soft_req = 1'b0;
        step(); check_s("min soft N+3", 1'b1, 1'b1, 1'b0, 2'b10);
        step(); check_s("min soft N+4", 1'b1, 1'b1, 1'b0, 2'b10);

        // Default soft reset with soft_req held until N+20.
        d_if.soft_req = 1'b1;
        for (int r = 0; r <= 22; r++) begin
            step();
            check_d($sformatf("soft N+%0d", r), {r >= 16, r >= 12, r >= 8},
                    r >= 17, (r >= 17) && (r <= 20), 2'b10);
            if (r == 20) d_if.soft_req = 1'b0;
        end
        d_if.soft_req = 1'b1;
        step();
        check_d("soft2 N", 3'b000, 1'b0, 1'b0, 2'b10);

        // Second soft reset with soft_req dropped at N+3: one-cycle ack.
        for (int r = 1; r <= 18; r++) begin
            step();
            check_d($sformatf("soft2 N+%0d", r), {r >= 16, r >= 12, r >= 8},
                    r >= 17, r == 17, 2'b10);
            if (r == 2) d_if.soft_req = 1'b0;
        end
        d_if.soft_req = 1'b1;
        step();
        check_d("soft2 N+19", 3'b000, 1'b0, 1'b0, 2'b10);
        d_if.soft_req = 1'b0;
        async_reset("mid-soft");

        // resetn pulse mid-RELEASE, then a full restart.
        por_check(22, 1'b0);
        async_reset("mid-release");
        por_check(27, 1'b0);

        // resetn pulse during ACK with soft_req held high.
        d_if.soft_req = 1'b1;
        for (int r = 0; r <= 18; r++) begin
            step();
            check_d($sformatf("ackrst N+%0d", r), {r >= 16, r >= 12, r >= 8},
                    r >= 17, r >= 17, 2'b10);
        end
        async_reset("in-ack");
        por_check(27, 1'b1);
        d_if.soft_req = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
